// File: rtl/matrix_mac_2x2.sv
// 2x2 matrix multiply-accumulate sequencer: walks the shared selector index 0..7,
// accumulates element products pairwise and publishes C = A x B with a done pulse.
// Optional build macro MATRIX_MAC_SIGNED_EN selects two's-complement elements.
module matrix_mac_2x2 #(
    parameter int          ELEM_W   = 3,
    parameter int          RES_W    = 2*ELEM_W+1,
    parameter logic [3:0]  IDLE_IDX = 4'hF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ELEM_W-1:0]    elem_a,
    input  logic [ELEM_W-1:0]    elem_b,
    output logic [3:0]           entry_out,
    output logic                 busy,
    output logic                 done,
    output logic [4*RES_W-1:0]   result
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [3:0]           entry_q, entry_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [RES_W-1:0]     acc_q, acc_d;
    logic [RES_W-1:0]     c00_q, c00_d;
    logic [RES_W-1:0]     c01_q, c01_d;
    logic [RES_W-1:0]     c10_q, c10_d;
    logic [4*RES_W-1:0]   result_q, result_d;
    logic [RES_W-1:0]     prod;
    logic [RES_W-1:0]     sum;

    // Full-width product extended to the result width (sign- or zero-extension by build).
    function automatic logic [RES_W-1:0] mul_ext(input logic [ELEM_W-1:0] a,
                                                 input logic [ELEM_W-1:0] b);
`ifdef MATRIX_MAC_SIGNED_EN
        logic signed [2*ELEM_W-1:0] p;
        logic signed [RES_W-1:0]    pe;
        p  = $signed(a) * $signed(b);
        pe = p;
        return pe;
`else
        logic [2*ELEM_W-1:0] p;
        p = a * b;
        return {{(RES_W-2*ELEM_W){1'b0}}, p};
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            entry_q  <= IDLE_IDX;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            acc_q    <= '0;
            c00_q    <= '0;
            c01_q    <= '0;
            c10_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            acc_q    <= acc_d;
            c00_q    <= c00_d;
            c01_q    <= c01_d;
            c10_q    <= c10_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        acc_d    = acc_q;
        c00_d    = c00_q;
        c01_d    = c01_q;
        c10_d    = c10_q;
        result_d = result_q;
        prod     = mul_ext(elem_a, elem_b);
        sum      = acc_q + prod;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    entry_d = 4'd0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                // Even index opens a pair, odd index closes it into its C element.
                if (!entry_q[0]) begin
                    acc_d = prod;
                end else begin
                    case (entry_q[2:1])
                        2'd0:    c00_d = sum;
                        2'd1:    c01_d = sum;
                        2'd2:    c10_d = sum;
                        default: result_d = {sum, c10_q, c01_q, c00_q};
                    endcase
                end
                if (entry_q[2:0] == 3'd7) begin
                    entry_d = IDLE_IDX;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    entry_d = entry_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign entry_out = entry_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;

endmodule

// File: tb/tb_matrix_mac_2x2.sv
// Bench for matrix_mac_2x2: negedge-registered selector models feed the DUT, and a
// phase-level reference model of C = A x B is compared against the outputs every cycle.
module tb_matrix_mac_2x2;

    localparam int ELEM_W = 3;
    localparam int RES_W  = 7;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [ELEM_W-1:0]   elem_a = '0;
    logic [ELEM_W-1:0]   elem_b = '0;
    logic [3:0]          entry_out;
    logic                busy;
    logic                done;
    logic [4*RES_W-1:0]  result;

    logic [2:0] A [4];
    logic [2:0] B [4];

    int checks = 0;
    int failures = 0;
    int ndone = 0;

    matrix_mac_2x2 dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .elem_a(elem_a), .elem_b(elem_b),
        .entry_out(entry_out), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Behavioural selectors: index -> element, IDLE index maps to element 0.
    always @(negedge clk) begin
        if (entry_out > 4'd7) begin
            elem_a <= A[0];
            elem_b <= B[0];
        end else begin
            elem_a <= A[{entry_out[2], entry_out[0]}];
            elem_b <= B[{entry_out[0], entry_out[1]}];
        end
    end

    function automatic int ev(input logic [2:0] x);
`ifdef MATRIX_MAC_SIGNED_EN
        return (x >= 3'd4) ? int'(x) - 8 : int'(x);
`else
        return int'(x);
`endif
    endfunction

    function automatic logic [4*RES_W-1:0] matmul();
        logic [RES_W-1:0]   c [4];
        int s;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int k = 0; k < 2; k++)
                    s += ev(A[i*2+k]) * ev(B[k*2+j]);
                c[i*2+j] = s[RES_W-1:0];
            end
        return {c[3], c[2], c[1], c[0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1..8 issuing index phase-1, 9 done cycle.
    int                m_phase = 0;
    logic [4*RES_W-1:0] m_result = '0;
    bit                m_valid = 0;

    initial begin
        logic s_rst, s_start;
        forever begin
            @(posedge clk);
            s_rst = rst_n;
            s_start = start;
            if (!s_rst) begin
                m_phase = 0;
                m_result = '0;
                m_valid = 1;
            end else if (m_phase == 0) begin
                if (s_start) m_phase = 1;
            end else if (m_phase < 9) begin
                m_phase++;
                if (m_phase == 9) m_result = matmul();
            end else begin
                m_phase = 0;
            end
            #1;
            if (m_valid) begin
                chk("entry_out", 32'(entry_out),
                    (m_phase >= 1 && m_phase <= 8) ? 32'(m_phase - 1) : 32'hF);
                chk("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= 8));
                chk("done", 32'(done), 32'(m_phase == 9));
                chk("result", 32'(result), 32'(m_result));
                if (done) ndone++;
            end
        end
    end

    task automatic set_mats(input int a00, a01, a10, a11, b00, b01, b10, b11);
        A[0] = 3'(a00); A[1] = 3'(a01); A[2] = 3'(a10); A[3] = 3'(a11);
        B[0] = 3'(b00); B[1] = 3'(b01); B[2] = 3'(b10); B[3] = 3'(b11);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic logic [31:0] pack(input int c00, c01, c10, c11);
        logic [4*RES_W-1:0] r;
        r = {7'(c11), 7'(c10), 7'(c01), 7'(c00)};
        return 32'(r);
    endfunction

    initial begin
        int d0;
        set_mats(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: done exactly 8 edges after the accepting edge.
        set_mats(1, 2, 3, 4, 5, 6, 7, 0);
        d0 = ndone;
        pulse_start();
        repeat (7) @(negedge clk);
        chk("t1_no_early_done", 32'(ndone - d0), 32'd0);
        @(negedge clk);
        chk("t1_done_count", 32'(ndone - d0), 32'd1);
        chk("t1_result", 32'(result), pack(19, 6, 43, 18));
        @(negedge clk);

        // Test 2: maximum unsigned operands.
        set_mats(7, 7, 7, 7, 7, 7, 7, 7);
        pulse_start();
        repeat (9) @(negedge clk);
`ifdef MATRIX_MAC_SIGNED_EN
        chk("t2_result", 32'(result), pack(2, 2, 2, 2));
`else
        chk("t2_result", 32'(result), pack(98, 98, 98, 98));
`endif

        // Test 3: identity, then back-to-back start right after the done cycle.
        set_mats(1, 0, 0, 1, 3, 5, 6, 2);
        pulse_start();
        repeat (9) @(negedge clk);
        chk("t3_result", 32'(result), pack(3, 5, 6, 2));
        d0 = ndone;
        pulse_start();
        repeat (9) @(negedge clk);
        chk("t3_b2b_done", 32'(ndone - d0), 32'd1);
        chk("t3_b2b_result", 32'(result), pack(3, 5, 6, 2));

        // Test 4: start re-asserted during RUN and during DONE is ignored.
        set_mats(1, 2, 3, 4, 5, 6, 7, 0);
        d0 = ndone;
        pulse_start();
        repeat (2) @(negedge clk);
        chk("t4_result_held", 32'(result), pack(3, 5, 6, 2));
        pulse_start();
        repeat (5) @(negedge clk);
        pulse_start();
        repeat (4) @(negedge clk);
        chk("t4_single_done", 32'(ndone - d0), 32'd1);
        chk("t4_idle_after", 32'(busy), 32'd0);

        // Test 5: reset during the 5th RUN cycle abandons the run.
        set_mats(2, 1, 1, 2, 1, 1, 1, 1);
        d0 = ndone;
        pulse_start();
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_reset_result", 32'(result), 32'd0);
        chk("t5_reset_entry", 32'(entry_out), 32'hF);
        repeat (6) @(negedge clk);
        chk("t5_no_done", 32'(ndone - d0), 32'd0);
        set_mats(1, 2, 3, 4, 5, 6, 7, 0);
        pulse_start();
        repeat (9) @(negedge clk);
        chk("t5_rerun_result", 32'(result), pack(19, 6, 43, 18));

        // Test 6: -1 x 2 in the signed build, 7 x 2 otherwise.
        set_mats(7, 7, 7, 7, 2, 2, 2, 2);
        pulse_start();
        repeat (9) @(negedge clk);
`ifdef MATRIX_MAC_SIGNED_EN
        chk("t6_result", 32'(result), pack(124, 124, 124, 124));
`else
        chk("t6_result", 32'(result), pack(28, 28, 28, 28));
`endif
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
